// File: rtl/ctrl.sv
// Main instruction decoder: maps opcode (and RS for coprocessor 0) to a
// registered 14-bit control word plus an illegal-opcode flag, one cycle latency.
module ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  OP,
    input  logic [4:0]  RS,
    output logic [13:0] signal,
    output logic        illegal
);

    localparam int unsigned CW_W = 14;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [4:0] RS_MFC0 = 5'h00;
    localparam logic [4:0] RS_MTC0 = 5'h04;
    localparam logic [4:0] RS_ERET = 5'h10;

    localparam logic [CW_W-1:0] CW_NOP    = 14'h0000;
    localparam logic [CW_W-1:0] CW_RTYPE  = 14'h18A0;
    localparam logic [CW_W-1:0] CW_J      = 14'h0001;
    localparam logic [CW_W-1:0] CW_JAL    = 14'h0121;
    localparam logic [CW_W-1:0] CW_BRANCH = 14'h0602;
    localparam logic [CW_W-1:0] CW_ALUIMM = 14'h0C20;
    localparam logic [CW_W-1:0] CW_LW     = 14'h0C70;
    localparam logic [CW_W-1:0] CW_SW     = 14'h0C08;
    localparam logic [CW_W-1:0] CW_LB     = 14'h2C70;
    localparam logic [CW_W-1:0] CW_SB     = 14'h2C08;
    localparam logic [CW_W-1:0] CW_MFC0   = 14'h0820;
    localparam logic [CW_W-1:0] CW_COP0   = 14'h0800;

    logic [CW_W-1:0] signal_c;
    logic            illegal_c;

    // Opcode decode; RS only matters for coprocessor 0.
    always_comb begin
        signal_c  = CW_NOP;
        illegal_c = 1'b0;
        case (OP)
            OP_RTYPE:        signal_c = CW_RTYPE;
            OP_J:            signal_c = CW_J;
            OP_JAL:          signal_c = CW_JAL;
            OP_BEQ, OP_BNE:  signal_c = CW_BRANCH;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:
                             signal_c = CW_ALUIMM;
            OP_LW:           signal_c = CW_LW;
            OP_SW:           signal_c = CW_SW;
            OP_LB, OP_LBU:   signal_c = CW_LB;
            OP_SB:           signal_c = CW_SB;
            OP_COP0: begin
                case (RS)
                    RS_MFC0:          signal_c = CW_MFC0;
                    RS_MTC0, RS_ERET: signal_c = CW_COP0;
                    default: begin
                        signal_c  = CW_COP0;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            default: begin
                signal_c  = CW_NOP;
                illegal_c = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            signal  <= CW_NOP;
            illegal <= 1'b0;
        end else begin
            signal  <= signal_c;
            illegal <= illegal_c;
        end
    end

endmodule

// File: tb/tb_ctrl.sv
// Self-checking bench for ctrl: table-driven reference model checked every
// cycle, plus directed literal scenarios and an exhaustive OP x RS invariant sweep.
module tb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  OP  = 6'h23;
    logic [4:0]  RS  = 5'h00;
    logic [13:0] signal;
    logic        illegal;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .OP      (OP),
        .RS      (RS),
        .signal  (signal),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    // Recognised non-coprocessor opcodes and their control words.
    logic [5:0]  tbl_op [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                 6'h20, 6'h23, 6'h24, 6'h28, 6'h2B};
    logic [13:0] tbl_w  [18] = '{14'h18A0, 14'h0001, 14'h0121, 14'h0602, 14'h0602,
                                 14'h0C20, 14'h0C20, 14'h0C20, 14'h0C20,
                                 14'h0C20, 14'h0C20, 14'h0C20, 14'h0C20,
                                 14'h2C70, 14'h0C70, 14'h2C70, 14'h2C08, 14'h0C08};

    // Returns {illegal, signal} for one OP/RS pair.
    function automatic logic [14:0] model(input logic [5:0] op, input logic [4:0] rs);
        logic [13:0] w;
        logic        ill;
        if (op == 6'h10) begin
            w   = (rs == 5'h00) ? 14'h0820 : 14'h0800;
            ill = !(rs == 5'h00 || rs == 5'h04 || rs == 5'h10);
        end else begin
            w   = 14'h0000;
            ill = 1'b1;
            for (int i = 0; i < 18; i++) begin
                if (tbl_op[i] == op) begin
                    w   = tbl_w[i];
                    ill = 1'b0;
                end
            end
        end
        return {ill, w};
    endfunction

    function automatic bit invariants_ok(input logic [13:0] s);
        return !(s[4] && s[3]) && !(s[1] && s[0]) &&
               (!s[6] || (s[5] && s[4])) && (s[8:7] != 2'd3) && (s[2] == 1'b0);
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ill=%0b sig=%h, want ill=%0b sig=%h",
                     name, act[14], act[13:0], exp[14], exp[13:0]);
        end
    endtask

    // Per-cycle compare against the model once reset has been seen.
    always @(posedge clk) begin
        automatic logic [14:0] e  = rst ? 15'h0 : model(OP, RS);
        automatic bit          go = armed || rst;
        if (rst) armed = 1'b1;
        #1;
        if (go) begin
            check("model", {illegal, signal}, e);
            checks++;
            if (!invariants_ok(signal)) begin
                errors++;
                $display("FAIL invariant: sig=%h violates control-word rules", signal);
            end
        end
    end

    // Drive one cycle of inputs and check the result against literals.
    task automatic apply(input logic [5:0] op, input logic [4:0] rs, input logic r,
                         input logic [13:0] exp_sig, input logic exp_ill, input string name);
        @(negedge clk);
        OP  = op;
        RS  = rs;
        rst = r;
        @(posedge clk);
        #2;
        check(name, {illegal, signal}, {exp_ill, exp_sig});
    endtask

    initial begin
        // Reset with lw present, then release.
        apply(6'h23, 5'h00, 1'b1, 14'h0000, 1'b0, "reset1");
        apply(6'h23, 5'h00, 1'b1, 14'h0000, 1'b0, "reset2");
        apply(6'h23, 5'h00, 1'b0, 14'h0C70, 1'b0, "first_lw");

        for (int i = 0; i < 18; i++)
            apply(tbl_op[i], 5'($urandom), 1'b0, tbl_w[i], 1'b0, "sweep");

        apply(6'h10, 5'h00, 1'b0, 14'h0820, 1'b0, "mfc0");
        apply(6'h10, 5'h04, 1'b0, 14'h0800, 1'b0, "mtc0");
        apply(6'h10, 5'h10, 1'b0, 14'h0800, 1'b0, "eret");
        apply(6'h10, 5'h1F, 1'b0, 14'h0800, 1'b1, "cop0_bad_rs");

        apply(6'h3F, 5'h00, 1'b0, 14'h0000, 1'b1, "op3f");
        apply(6'h01, 5'h00, 1'b0, 14'h0000, 1'b1, "op01");
        apply(6'h00, 5'h00, 1'b0, 14'h18A0, 1'b0, "rtype_after_bad");

        apply(6'h04, 5'h00, 1'b0, 14'h0602, 1'b0, "b2b_beq");
        apply(6'h2B, 5'h00, 1'b1, 14'h0000, 1'b0, "b2b_rst");
        apply(6'h03, 5'h00, 1'b0, 14'h0121, 1'b0, "b2b_jal");

        // Exhaustive OP x RS; per-cycle process checks model and invariants.
        for (int op = 0; op < 64; op++) begin
            for (int rs = 0; rs < 32; rs++) begin
                @(negedge clk);
                OP  = 6'(op);
                RS  = 5'(rs);
                rst = 1'b0;
            end
        end

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            OP  = ($urandom_range(0, 3) == 0) ? 6'h10 : 6'($urandom);
            RS  = 5'($urandom);
            rst = ($urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl.md
CTRL -- requirements
Module: ctrl

Interface
REQ-001 Parameters: none; all widths and encodings below are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 OP  input  6  opcode field, instruction bits 31:26.
REQ-005 RS  input  5  instruction bits 25:21; used only to qualify opcode 0x10 (coprocessor).
REQ-006 signal  output  14  registered control word.
REQ-007 illegal  output  1  registered flag, 1 = unrecognised opcode.

Function
REQ-008 signal bit map:
- 13 = Membyte (byte/halfword memory access).
- 12 = ALUOP (ALU function taken from the func field).
- 11 = SA (1 = A is RA, 0 = A is PC).
- 10:9 = SB (0 = RB, 1 = constant 4, 2 = sign-extended immediate, 3 = immediate<<1).
- 8:7 = RegDst (0 = RT, 1 = RD, 2 = register 31, 3 = unused).
- 6 = Mem2Reg; 5 = RegW; 4 = MemR; 3 = MemW.
- 2 = PC_S (reserved, always 0).
- 1 = PCWC (conditional PC write); 0 = PCW (unconditional jump).
REQ-009 Combinational decode of OP/RS; the result is registered into signal and illegal on every rising clk edge.
- Latency: exactly 1 cycle.
- Outputs hold steady while OP/RS are stable.
REQ-010 Decode table (hex):
- OP 00 (R-type) -> 18A0.
- OP 02 (j) -> 0001.
- OP 03 (jal) -> 0121.
- OP 04 (beq), 05 (bne) -> 0602.
- OP 08, 09, 0A, 0B, 0C, 0D, 0E, 0F (immediate ALU/lui) -> 0C20.
- OP 23 (lw) -> 0C70.
- OP 2B (sw) -> 0C08.
- OP 20 (lb), 24 (lbu) -> 2C70.
- OP 28 (sb) -> 2C08.
REQ-011 OP 10 (coprocessor 0):
- RS=00 (mfc0) -> 0820.
- RS=04 (mtc0) -> 0800.
- RS=10 (eret) -> 0800.
- Any other RS -> 0800 with illegal=1.
REQ-012 Any OP not listed in REQ-010/REQ-011 -> signal 0000 (NOP behaviour: no register, memory or PC write) and illegal=1.
REQ-013 illegal=0 for every recognised OP (and recognised OP/RS combination).
REQ-014 Mutual-exclusion invariants, for every input: MemR and MemW never both 1; PCW and PCWC never both 1; Mem2Reg=1 implies RegW=1 and MemR=1; RegDst never 3; PC_S always 0.
REQ-015 No internal state other than the two output registers; RS is ignored for all OP other than 10.

Reset
REQ-016 On a rising edge with rst=1: signal=0000 and illegal=0, regardless of OP/RS.
REQ-017 rst dominates decode in the same cycle.
REQ-018 The first decode is visible on the rising edge following the first cycle with rst=0.
REQ-019 rst asserted mid-stream clears both outputs at the next edge; no partial decode persists.
REQ-020 Before the first reset, outputs are undefined; the bench applies reset first.

Verification
REQ-021 rst=1 for 2 cycles with OP=23 -> signal=0000, illegal=0; release rst, hold OP=23 -> next edge signal=0C70, illegal=0.
REQ-022 Sweep OP 00, 02, 03, 04, 05, 08..0F, 20, 23, 24, 28, 2B, one per cycle -> each table value appears exactly one edge after OP is applied; illegal=0 throughout.
REQ-023 OP=10 with RS=00, 04, 10, 1F -> signal 0820, 0800, 0800, 0800; illegal 0, 0, 0, 1.
REQ-024 OP=3F and OP=01 -> signal=0000, illegal=1; then OP=00 -> 18A0, illegal=0.
REQ-025 Back-to-back OP=04 then 2B then 03, with rst pulsed high during the 2B cycle -> outputs 0602, then 0000 (reset), then 0121.
REQ-026 Exhaustive sweep of all 64 OP x 32 RS -> the REQ-014 invariants hold on every output.
